gbpt_update_queue: RTL and testbench

//   Initiator side of the GBPT update0/update1 interface. Buffers resolved branch

---
 rtl/gbpt_update_queue.sv | 110 +++++++++++
 tb/tb_gbpt_update_queue.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbpt_update_queue.sv
// GBPT update initiator: buffers resolved branches in a small FIFO, issues one update0 per
// cycle, pairs the update1 response with the issued tag and keeps saturating accuracy counters.
module gbpt_update_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned TAG_WIDTH  = 7,
    parameter int unsigned GH_LENGTH  = 8,
    parameter int unsigned ASID_WIDTH = 9
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  enq_valid,
    output logic                  enq_ready,
    input  logic [31:0]           enq_start_full_PC,
    input  logic [GH_LENGTH-1:0]  enq_GH,
    input  logic [ASID_WIDTH-1:0] enq_ASID,
    input  logic                  enq_taken,
    input  logic [TAG_WIDTH-1:0]  enq_tag,
    input  logic                  update_hold,
    output logic                  update0_valid,
    output logic [31:0]           update0_start_full_PC,
    output logic [GH_LENGTH-1:0]  update0_GH,
    output logic [ASID_WIDTH-1:0] update0_ASID,
    output logic                  update0_taken,
    input  logic                  update1_correct,
    output logic                  resp_valid,
    output logic [TAG_WIDTH-1:0]  resp_tag,
    output logic                  resp_correct,
    output logic [31:0]           perf_update_count,
    output logic [31:0]           perf_correct_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0]           pc;
        logic [GH_LENGTH-1:0]  gh;
        logic [ASID_WIDTH-1:0] asid;
        logic                  taken;
        logic [TAG_WIDTH-1:0]  tag;
    } entry_t;

    entry_t                fifo_q [DEPTH];
    logic   [IDX_W:0]      head_q;
    logic   [IDX_W:0]      tail_q;
    logic                  u1_valid_q;
    logic   [TAG_WIDTH-1:0] u1_tag_q;
    logic   [31:0]         upd_cnt_q;
    logic   [31:0]         cor_cnt_q;

    logic   empty;
    logic   full;
    logic   enq_fire;
    entry_t head_entry;
    entry_t enq_entry;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty = (head_q == tail_q);
    assign full  = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[IDX_W] != tail_q[IDX_W]);

    assign enq_ready = !full;
    assign enq_fire  = enq_valid && !full;
    assign enq_entry = '{pc: enq_start_full_PC, gh: enq_GH, asid: enq_ASID,
                         taken: enq_taken, tag: enq_tag};

    assign head_entry            = fifo_q[head_q[IDX_W-1:0]];
    assign update0_valid         = !empty && !update_hold;
    assign update0_start_full_PC = head_entry.pc;
    assign update0_GH            = head_entry.gh;
    assign update0_ASID          = head_entry.asid;
    assign update0_taken         = head_entry.taken;

    assign resp_valid         = u1_valid_q;
    assign resp_tag           = u1_tag_q;
    assign resp_correct       = u1_valid_q && update1_correct;
    assign perf_update_count  = upd_cnt_q;
    assign perf_correct_count = cor_cnt_q;

    always_ff @(posedge CLK) begin
        if (enq_fire) begin
            fifo_q[tail_q[IDX_W-1:0]] <= enq_entry;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_q     <= '0;
            tail_q     <= '0;
            u1_valid_q <= 1'b0;
            u1_tag_q   <= '0;
            upd_cnt_q  <= '0;
            cor_cnt_q  <= '0;
        end else begin
            if (enq_fire) begin
                tail_q <= tail_q + 1'b1;
            end
            if (update0_valid) begin
                head_q <= head_q + 1'b1;
            end
            u1_valid_q <= update0_valid;
            u1_tag_q   <= head_entry.tag;
            if (resp_valid && (upd_cnt_q != 32'hFFFF_FFFF)) begin
                upd_cnt_q <= upd_cnt_q + 32'd1;
            end
            if (resp_correct && (cor_cnt_q != 32'hFFFF_FFFF)) begin
                cor_cnt_q <= cor_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_gbpt_update_queue.sv
// Scoreboard bench for gbpt_update_queue: queued entries and in-flight response tags are
// modelled in the bench and compared against the DUT each cycle.
module tb_gbpt_update_queue;

    localparam int DEPTH      = 4;
    localparam int TAG_WIDTH  = 7;
    localparam int GH_LENGTH  = 8;
    localparam int ASID_WIDTH = 9;

    logic                  CLK = 1'b0;
    logic                  nRST;
    logic                  enq_valid;
    logic                  enq_ready;
    logic [31:0]           enq_start_full_PC;
    logic [GH_LENGTH-1:0]  enq_GH;
    logic [ASID_WIDTH-1:0] enq_ASID;
    logic                  enq_taken;
    logic [TAG_WIDTH-1:0]  enq_tag;
    logic                  update_hold;
    logic                  update0_valid;
    logic [31:0]           update0_start_full_PC;
    logic [GH_LENGTH-1:0]  update0_GH;
    logic [ASID_WIDTH-1:0] update0_ASID;
    logic                  update0_taken;
    logic                  update1_correct;
    logic                  resp_valid;
    logic [TAG_WIDTH-1:0]  resp_tag;
    logic                  resp_correct;
    logic [31:0]           perf_update_count;
    logic [31:0]           perf_correct_count;

    always #5 CLK = ~CLK;

    gbpt_update_queue #(
        .DEPTH      (DEPTH),
        .TAG_WIDTH  (TAG_WIDTH),
        .GH_LENGTH  (GH_LENGTH),
        .ASID_WIDTH (ASID_WIDTH)
    ) dut (
        .CLK                   (CLK),
        .nRST                  (nRST),
        .enq_valid             (enq_valid),
        .enq_ready             (enq_ready),
        .enq_start_full_PC     (enq_start_full_PC),
        .enq_GH                (enq_GH),
        .enq_ASID              (enq_ASID),
        .enq_taken             (enq_taken),
        .enq_tag               (enq_tag),
        .update_hold           (update_hold),
        .update0_valid         (update0_valid),
        .update0_start_full_PC (update0_start_full_PC),
        .update0_GH            (update0_GH),
        .update0_ASID          (update0_ASID),
        .update0_taken         (update0_taken),
        .update1_correct       (update1_correct),
        .resp_valid            (resp_valid),
        .resp_tag              (resp_tag),
        .resp_correct          (resp_correct),
        .perf_update_count     (perf_update_count),
        .perf_correct_count    (perf_correct_count)
    );

    typedef struct packed {
        logic [31:0]           pc;
        logic [GH_LENGTH-1:0]  gh;
        logic [ASID_WIDTH-1:0] asid;
        logic                  taken;
        logic [TAG_WIDTH-1:0]  tag;
    } ent_t;

    ent_t                 exp_q[$];
    int                   occ;
    logic                 pend;
    logic [TAG_WIDTH-1:0] pend_tag;
    logic [31:0]          m_upd;
    logic [31:0]          m_cor;
    logic                 exp_ready;
    logic                 exp_u0v;
    logic                 exp_rc;
    int                   passed = 0;
    int                   total  = 0;

    task automatic model_reset();
        exp_q.delete();
        occ      = 0;
        pend     = 1'b0;
        pend_tag = '0;
        m_upd    = '0;
        m_cor    = '0;
    endtask

    // Called at posedge+1: applies this cycle's inputs and derives the expected outputs.
    task automatic drive(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [TAG_WIDTH-1:0] tg, input logic hold, input logic corr);
        enq_valid         = v;
        enq_start_full_PC = pc;
        enq_GH            = GH_LENGTH'({tg, 1'b1});
        enq_ASID          = ASID_WIDTH'({2'b10, tg});
        enq_taken         = tk;
        enq_tag           = tg;
        update_hold       = hold;
        update1_correct   = corr;
        exp_ready         = (occ < DEPTH);
        exp_u0v           = (occ != 0) && !hold;
        exp_rc            = pend && corr;
        #1;
    endtask

    // Advances the model across the coming edge, then waits for it.
    task automatic advance();
        ent_t e;
        if (pend) begin
            if (m_upd != 32'hFFFF_FFFF) m_upd = m_upd + 32'd1;
            if (update1_correct && (m_cor != 32'hFFFF_FFFF)) m_cor = m_cor + 32'd1;
        end
        if (exp_u0v) begin
            e        = exp_q.pop_front();
            pend_tag = e.tag;
            occ      = occ - 1;
        end
        if (enq_valid && exp_ready) begin
            e = '{pc: enq_start_full_PC, gh: enq_GH, asid: enq_ASID, taken: enq_taken,
                  tag: enq_tag};
            exp_q.push_back(e);
            occ = occ + 1;
        end
        pend = exp_u0v;
        @(posedge CLK);
        #1;
    endtask

    task automatic hw_reset();
        nRST = 1'b0;
        drive(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b0);
        model_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        drive(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if ({enq_ready, update0_valid, resp_valid, resp_correct, resp_tag} !== {4'b1000, 7'd0})
            $display("FAIL reset_flags: got rdy/u0v/rv/rc/tag=%b want 10000000000",
                     {enq_ready, update0_valid, resp_valid, resp_correct, resp_tag});
        else passed++;
        total++;
        if ({perf_update_count, perf_correct_count} !== 64'd0)
            $display("FAIL reset_counters: got %0d/%0d want 0/0",
                     perf_update_count, perf_correct_count);
        else passed++;
        nRST = 1'b1;
    endtask

    task automatic test_single();
        for (int c = 0; c < 5; c++) begin
            drive(c == 0, 32'h1000, 1'b1, 7'd5, 1'b0, 1'b0);
            total++;
            if ({enq_ready, update0_valid, resp_valid, resp_correct} !== {exp_ready, exp_u0v, pend, exp_rc})
                $display("FAIL single_flags c%0d: got %b want %b", c,
                         {enq_ready, update0_valid, resp_valid, resp_correct},
                         {exp_ready, exp_u0v, pend, exp_rc});
            else passed++;
            if (occ != 0) begin
                total++;
                if ({update0_start_full_PC, update0_GH, update0_ASID, update0_taken} !==
                    {exp_q[0].pc, exp_q[0].gh, exp_q[0].asid, exp_q[0].taken})
                    $display("FAIL single_head c%0d: got pc %h want %h", c,
                             update0_start_full_PC, exp_q[0].pc);
                else passed++;
            end
            if (pend) begin
                total++;
                if (resp_tag !== pend_tag)
                    $display("FAIL single_tag c%0d: got %0d want %0d", c, resp_tag, pend_tag);
                else passed++;
            end
            total++;
            if ({perf_update_count, perf_correct_count} !== {m_upd, m_cor})
                $display("FAIL single_cnt c%0d: got %0d/%0d want %0d/%0d", c,
                         perf_update_count, perf_correct_count, m_upd, m_cor);
            else passed++;
            if (c == 3) begin
                total++;
                if (perf_update_count !== 32'd1)
                    $display("FAIL single_perf1: got %0d want 1", perf_update_count);
                else passed++;
            end
            advance();
        end
    endtask

    task automatic test_fill_drain();
        for (int c = 0; c < 11; c++) begin
            drive(c < 5, 32'h2000 + 32'(c * 4), c[0], 7'(c), c < 5, 1'b0);
            total++;
            if ({enq_ready, update0_valid, resp_valid, resp_correct} !== {exp_ready, exp_u0v, pend, exp_rc})
                $display("FAIL fill_flags c%0d: got %b want %b", c,
                         {enq_ready, update0_valid, resp_valid, resp_correct},
                         {exp_ready, exp_u0v, pend, exp_rc});
            else passed++;
            if (occ != 0) begin
                total++;
                if ({update0_start_full_PC, update0_GH, update0_ASID, update0_taken} !==
                    {exp_q[0].pc, exp_q[0].gh, exp_q[0].asid, exp_q[0].taken})
                    $display("FAIL fill_head c%0d: got pc %h want %h", c,
                             update0_start_full_PC, exp_q[0].pc);
                else passed++;
            end
            if (pend) begin
                total++;
                if (resp_tag !== pend_tag)
                    $display("FAIL fill_tag c%0d: got %0d want %0d", c, resp_tag, pend_tag);
                else passed++;
            end
            total++;
            if ({perf_update_count, perf_correct_count} !== {m_upd, m_cor})
                $display("FAIL fill_cnt c%0d: got %0d/%0d want %0d/%0d", c,
                         perf_update_count, perf_correct_count, m_upd, m_cor);
            else passed++;
            if (c == 4) begin
                total++;
                if (enq_ready !== 1'b0)
                    $display("FAIL fill_full: got enq_ready %b want 0", enq_ready);
                else passed++;
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 16; c++) begin
            drive(c < 12, 32'h3000 + 32'(c * 16), ~c[0], 7'(10 + c), c < 2, 1'b0);
            total++;
            if ({enq_ready, update0_valid, resp_valid, resp_correct} !== {exp_ready, exp_u0v, pend, exp_rc})
                $display("FAIL b2b_flags c%0d: got %b want %b", c,
                         {enq_ready, update0_valid, resp_valid, resp_correct},
                         {exp_ready, exp_u0v, pend, exp_rc});
            else passed++;
            if (occ != 0) begin
                total++;
                if ({update0_start_full_PC, update0_GH, update0_ASID, update0_taken} !==
                    {exp_q[0].pc, exp_q[0].gh, exp_q[0].asid, exp_q[0].taken})
                    $display("FAIL b2b_head c%0d: got pc %h want %h", c,
                             update0_start_full_PC, exp_q[0].pc);
                else passed++;
            end
            if (pend) begin
                total++;
                if (resp_tag !== pend_tag)
                    $display("FAIL b2b_tag c%0d: got %0d want %0d", c, resp_tag, pend_tag);
                else passed++;
            end
            total++;
            if ({perf_update_count, perf_correct_count} !== {m_upd, m_cor})
                $display("FAIL b2b_cnt c%0d: got %0d/%0d want %0d/%0d", c,
                         perf_update_count, perf_correct_count, m_upd, m_cor);
            else passed++;
            advance();
        end
    endtask

    task automatic test_hold_pulse();
        for (int c = 0; c < 10; c++) begin
            drive(c < 6, 32'h4000 + 32'(c * 8), 1'b1, 7'(30 + c), c == 3, 1'b0);
            total++;
            if ({enq_ready, update0_valid, resp_valid, resp_correct} !== {exp_ready, exp_u0v, pend, exp_rc})
                $display("FAIL hold_flags c%0d: got %b want %b", c,
                         {enq_ready, update0_valid, resp_valid, resp_correct},
                         {exp_ready, exp_u0v, pend, exp_rc});
            else passed++;
            if (occ != 0) begin
                total++;
                if ({update0_start_full_PC, update0_GH, update0_ASID, update0_taken} !==
                    {exp_q[0].pc, exp_q[0].gh, exp_q[0].asid, exp_q[0].taken})
                    $display("FAIL hold_head c%0d: got pc %h want %h", c,
                             update0_start_full_PC, exp_q[0].pc);
                else passed++;
            end
            if (pend) begin
                total++;
                if (resp_tag !== pend_tag)
                    $display("FAIL hold_tag c%0d: got %0d want %0d", c, resp_tag, pend_tag);
                else passed++;
            end
            total++;
            if ({perf_update_count, perf_correct_count} !== {m_upd, m_cor})
                $display("FAIL hold_cnt c%0d: got %0d/%0d want %0d/%0d", c,
                         perf_update_count, perf_correct_count, m_upd, m_cor);
            else passed++;
            advance();
        end
    endtask

    task automatic test_correct();
        hw_reset();
        for (int c = 0; c < 8; c++) begin
            drive(c < 3, 32'h5000 + 32'(c * 32), c[0], 7'(40 + c), c < 3, (c == 4) || (c == 6));
            total++;
            if ({enq_ready, update0_valid, resp_valid, resp_correct} !== {exp_ready, exp_u0v, pend, exp_rc})
                $display("FAIL corr_flags c%0d: got %b want %b", c,
                         {enq_ready, update0_valid, resp_valid, resp_correct},
                         {exp_ready, exp_u0v, pend, exp_rc});
            else passed++;
            if (occ != 0) begin
                total++;
                if ({update0_start_full_PC, update0_GH, update0_ASID, update0_taken} !==
                    {exp_q[0].pc, exp_q[0].gh, exp_q[0].asid, exp_q[0].taken})
                    $display("FAIL corr_head c%0d: got pc %h want %h", c,
                             update0_start_full_PC, exp_q[0].pc);
                else passed++;
            end
            if (pend) begin
                total++;
                if (resp_tag !== pend_tag)
                    $display("FAIL corr_tag c%0d: got %0d want %0d", c, resp_tag, pend_tag);
                else passed++;
            end
            total++;
            if ({perf_update_count, perf_correct_count} !== {m_upd, m_cor})
                $display("FAIL corr_cnt c%0d: got %0d/%0d want %0d/%0d", c,
                         perf_update_count, perf_correct_count, m_upd, m_cor);
            else passed++;
            advance();
        end
        total++;
        if ({perf_update_count, perf_correct_count} !== {32'd3, 32'd2})
            $display("FAIL corr_totals: got %0d/%0d want 3/2", perf_update_count,
                     perf_correct_count);
        else passed++;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 32'h6000 + 32'(c * 4), 1'b1, 7'(50 + c), c < 3, 1'b0);
            advance();
        end
        drive(1'b0, 32'h0, 1'b0, '0, 1'b1, 1'b1);
        total++;
        if ({resp_valid, resp_tag, enq_ready} !== {1'b1, 7'd50, 1'b1})
            $display("FAIL mid_pre: got rv/tag/rdy=%b/%0d/%b want 1/50/1",
                     resp_valid, resp_tag, enq_ready);
        else passed++;
        nRST = 1'b0;
        #1;
        total++;
        if ({resp_valid, resp_correct, enq_ready, update0_valid} !== 4'b0010)
            $display("FAIL mid_async: got rv/rc/rdy/u0v=%b want 0010",
                     {resp_valid, resp_correct, enq_ready, update0_valid});
        else passed++;
        total++;
        if ({perf_update_count, perf_correct_count} !== 64'd0)
            $display("FAIL mid_counters: got %0d/%0d want 0/0", perf_update_count,
                     perf_correct_count);
        else passed++;
        model_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b0);
            total++;
            if ({update0_valid, resp_valid} !== 2'b00)
                $display("FAIL mid_stale c%0d: got u0v/rv=%b want 00", c,
                         {update0_valid, resp_valid});
            else passed++;
            advance();
        end
        drive(1'b1, 32'h7000, 1'b0, 7'd60, 1'b0, 1'b0);
        advance();
        drive(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b0);
        total++;
        if ({update0_valid, update0_start_full_PC} !== {1'b1, 32'h7000})
            $display("FAIL mid_new: got u0v/pc=%b/%h want 1/7000", update0_valid,
                     update0_start_full_PC);
        else passed++;
        advance();
        total++;
        if ({resp_valid, resp_tag} !== {1'b1, 7'd60})
            $display("FAIL mid_resp: got rv/tag=%b/%0d want 1/60", resp_valid, resp_tag);
        else passed++;
    endtask

    initial begin
        test_reset();
        @(posedge CLK);
        #1;
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_hold_pulse();
        test_correct();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
